// File: rtl/addr_ctrl_if.sv
// Bus between the address generator / read side and the shared-buffer address manager.
// Master = requester side, slave = addr_ctrl.
interface addr_ctrl_if;
   logic         req_addr;
   logic         req_done;
   logic         addr_done;
   logic [516:0] addr_use;
   logic         free_vld;
   logic         free_rdy;
   logic [4:0]   free_sram;
   logic [8:0]   free_start;
   logic [7:0]   free_len;
   logic [287:0] sram_idle_cnt;
   logic [287:0] sram_addr;
   logic         scan_busy;

   modport master (
      output req_addr, addr_done, addr_use, free_vld, free_sram, free_start, free_len,
      input  req_done, free_rdy, sram_idle_cnt, sram_addr, scan_busy
   );

   modport slave (
      input  req_addr, addr_done, addr_use, free_vld, free_sram, free_start, free_len,
      output req_done, free_rdy, sram_idle_cnt, sram_addr, scan_busy
   );
endinterface

// File: rtl/addr_ctrl.sv
// Shared-buffer address manager: per-block occupancy bitmap for 32 SRAMs x 512 blocks,
// grants allocations, accepts releases and rescans the touched SRAM for its largest free run.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | accept a release (priority) or an allocation request
// S_GRANT    | req_done pulse; requester samples status now
// S_WAIT_USE | wait for addr_done, latch addr_use
// S_UPDATE   | OR latched mask into the target SRAM bitmap
// S_FREE_UPD | clear the released block range in the target SRAM bitmap
// S_SCAN     | walk blocks 0..511 of the target SRAM, one per cycle
// S_COMMIT   | publish best run length/start for the target SRAM
module addr_ctrl (
   input  logic       sys_clk,
   input  logic       sys_rst,
   addr_ctrl_if.slave bus
);
   localparam int SRAM_NUM = 32;
   localparam int BLK_NUM  = 512;
   localparam int LAST_BLK = BLK_NUM - 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_WAIT_USE,
      S_UPDATE,
      S_FREE_UPD,
      S_SCAN,
      S_COMMIT
   } state_t;

   state_t state_q;
   state_t state_nxt;

   logic [BLK_NUM-1:0]    bitmap [SRAM_NUM];
   logic [4:0]            scan_sram_q;
   logic [BLK_NUM-1:0]    use_mask_q;
   logic [8:0]            free_start_q;
   logic [7:0]            free_len_q;
   logic [8:0]            scan_idx_q;
   logic [9:0]            run_len_q;
   logic [8:0]            run_start_q;
   logic [9:0]            best_len_q;
   logic [8:0]            best_start_q;
   logic [9*SRAM_NUM-1:0] idle_cnt_q;
   logic [9*SRAM_NUM-1:0] addr_q;

   logic                  scan_bit;
   logic                  scan_last;
   logic [9:0]            run_len_nxt;
   logic [8:0]            run_start_nxt;
   logic [9:0]            cand_len;
   logic [8:0]            cand_start;
   logic [9:0]            best_len_nxt;
   logic [8:0]            best_start_nxt;
   logic [9:0]            free_end;
   logic [BLK_NUM-1:0]    free_mask;
   logic [8:0]            commit_cnt;

   assign bus.req_done      = (state_q == S_GRANT);
   assign bus.free_rdy      = (state_q == S_IDLE) && !sys_rst;
   assign bus.scan_busy     = (state_q == S_UPDATE) || (state_q == S_FREE_UPD) ||
                              (state_q == S_SCAN)   || (state_q == S_COMMIT);
   assign bus.sram_idle_cnt = idle_cnt_q;
   assign bus.sram_addr     = addr_q;

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         S_IDLE: begin
            if (bus.free_vld)
               state_nxt = S_FREE_UPD;
            else if (bus.req_addr)
               state_nxt = S_GRANT;
         end
         S_GRANT:    state_nxt = S_WAIT_USE;
         S_WAIT_USE: if (bus.addr_done) state_nxt = S_UPDATE;
         S_UPDATE:   state_nxt = S_SCAN;
         S_FREE_UPD: state_nxt = S_SCAN;
         S_SCAN:     if (scan_last) state_nxt = S_COMMIT;
         S_COMMIT:   state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   // A run is only a candidate once it ends: on a used block or at the last block.
   always_comb begin
      scan_bit       = bitmap[scan_sram_q][scan_idx_q];
      scan_last      = (scan_idx_q == 9'(LAST_BLK));
      run_len_nxt    = '0;
      run_start_nxt  = run_start_q;
      if (!scan_bit) begin
         run_len_nxt   = run_len_q + 10'd1;
         run_start_nxt = (run_len_q == '0) ? scan_idx_q : run_start_q;
      end
      cand_len       = scan_bit ? run_len_q   : run_len_nxt;
      cand_start     = scan_bit ? run_start_q : run_start_nxt;
      best_len_nxt   = best_len_q;
      best_start_nxt = best_start_q;
      if ((scan_bit || scan_last) && (cand_len > best_len_q)) begin
         best_len_nxt   = cand_len;
         best_start_nxt = cand_start;
      end
   end

   // Release range end is exclusive; blocks past 511 simply have no mask bit.
   always_comb begin
      free_mask = '0;
      free_end  = {1'b0, free_start_q} + {2'b00, free_len_q};
      for (int j = 0; j < BLK_NUM; j++)
         free_mask[j] = (10'(j) >= {1'b0, free_start_q}) && (10'(j) < free_end);
   end

   assign commit_cnt = (best_len_q > 10'(LAST_BLK)) ? 9'(LAST_BLK) : best_len_q[8:0];

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q      <= S_IDLE;
         for (int k = 0; k < SRAM_NUM; k++)
            bitmap[k] <= '0;
         scan_sram_q  <= '0;
         use_mask_q   <= '0;
         free_start_q <= '0;
         free_len_q   <= '0;
         scan_idx_q   <= '0;
         run_len_q    <= '0;
         run_start_q  <= '0;
         best_len_q   <= '0;
         best_start_q <= '0;
         idle_cnt_q   <= {SRAM_NUM{9'd511}};
         addr_q       <= '0;
      end else begin
         state_q <= state_nxt;
         case (state_q)
            S_IDLE: begin
               if (bus.free_vld) begin
                  scan_sram_q  <= bus.free_sram;
                  free_start_q <= bus.free_start;
                  free_len_q   <= bus.free_len;
               end
            end
            S_WAIT_USE: begin
               if (bus.addr_done) begin
                  scan_sram_q <= bus.addr_use[516:512];
                  use_mask_q  <= bus.addr_use[511:0];
               end
            end
            S_UPDATE, S_FREE_UPD: begin
               if (state_q == S_UPDATE)
                  bitmap[scan_sram_q] <= bitmap[scan_sram_q] | use_mask_q;
               else
                  bitmap[scan_sram_q] <= bitmap[scan_sram_q] & ~free_mask;
               scan_idx_q   <= '0;
               run_len_q    <= '0;
               run_start_q  <= '0;
               best_len_q   <= '0;
               best_start_q <= '0;
            end
            S_SCAN: begin
               scan_idx_q   <= scan_idx_q + 9'd1;
               run_len_q    <= run_len_nxt;
               run_start_q  <= run_start_nxt;
               best_len_q   <= best_len_nxt;
               best_start_q <= best_start_nxt;
            end
            S_COMMIT: begin
               idle_cnt_q[int'(scan_sram_q)*9 +: 9] <= commit_cnt;
               addr_q[int'(scan_sram_q)*9 +: 9]     <= best_start_q;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_addr_ctrl.sv
// Scoreboard bench for addr_ctrl: directed scenarios plus random allocate/release traffic,
// checked against a run-length model of the occupancy bitmap.
module tb_addr_ctrl;
   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;
   always #5 sys_clk = ~sys_clk;

   addr_ctrl_if bus ();
   addr_ctrl dut (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus));

   typedef struct {
      logic [287:0] cnt;
      logic [287:0] addr;
      int           sram;
   } exp_t;

   exp_t exp_q[$];
   bit   mdl [32][512];
   int   mcnt [32];
   int   maddr [32];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [287:0] act, input logic [287:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Largest free run: examine every run start directly, keep the first longest one.
   task automatic calc(input int s, output int cnt, output int st);
      int best, bst, l;
      best = 0;
      bst  = 0;
      for (int b = 0; b < 512; b++) begin
         if (!mdl[s][b] && (b == 0 || mdl[s][b-1])) begin
            l = 0;
            while (b + l < 512 && !mdl[s][b+l]) l++;
            if (l > best) begin
               best = l;
               bst  = b;
            end
         end
      end
      cnt = (best > 511) ? 511 : best;
      st  = (best == 0) ? 0 : bst;
   endtask

   function automatic logic [287:0] pack(input int v [32]);
      logic [287:0] r;
      r = '0;
      for (int k = 0; k < 32; k++) r[k*9 +: 9] = 9'(v[k]);
      return r;
   endfunction

   function automatic logic [511:0] rng(input int lo, input int hi);
      logic [511:0] m;
      m = '0;
      for (int j = 0; j < 512; j++) if (j >= lo && j <= hi) m[j] = 1'b1;
      return m;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 32; s++) begin
         for (int b = 0; b < 512; b++) mdl[s][b] = 1'b0;
         mcnt[s]  = 511;
         maddr[s] = 0;
      end
   endtask

   task automatic push_exp(input int s);
      int c, a;
      exp_t e;
      calc(s, c, a);
      mcnt[s]  = c;
      maddr[s] = a;
      e.cnt  = pack(mcnt);
      e.addr = pack(maddr);
      e.sram = s;
      exp_q.push_back(e);
   endtask

   // Monitor: every completed rescan (busy falling outside reset) must match the next expectation.
   initial begin
      bit   prev_busy;
      exp_t e;
      prev_busy = 1'b0;
      forever begin
         @(negedge sys_clk);
         if (sys_rst) begin
            prev_busy = 1'b0;
         end else begin
            if (prev_busy && !bus.scan_busy) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_commit: got commit expected none");
               end else begin
                  e = exp_q.pop_front();
                  chk($sformatf("slot%0d_cnt", e.sram), bus.sram_idle_cnt[e.sram*9 +: 9], e.cnt[e.sram*9 +: 9]);
                  chk($sformatf("slot%0d_addr", e.sram), bus.sram_addr[e.sram*9 +: 9], e.addr[e.sram*9 +: 9]);
                  chk("all_cnt", bus.sram_idle_cnt, e.cnt);
                  chk("all_addr", bus.sram_addr, e.addr);
               end
            end
            prev_busy = bus.scan_busy;
         end
      end
   end

   task automatic wait_done(input string tag, input int exp_busy);
      int n, cyc;
      bit bad;
      n   = 0;
      bad = 1'b0;
      for (cyc = 0; cyc < 1000; cyc++) begin
         @(negedge sys_clk);
         if (bus.scan_busy) begin
            n++;
            if (bus.free_rdy || bus.req_done) bad = 1'b1;
         end
         if (bus.free_rdy) break;
      end
      if (cyc == 1000) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no IDLE expected IDLE within 1000 cycles", tag);
      end
      chk({tag, "_busy_cycles"}, n, exp_busy);
      chk({tag, "_busy_handshake"}, bad, 0);
   endtask

   task automatic do_alloc(input int s, input logic [511:0] m);
      @(posedge sys_clk); #1;
      bus.req_addr = 1'b1;
      @(negedge sys_clk);
      chk("grant_early", bus.req_done, 0);
      @(posedge sys_clk); #1;
      @(negedge sys_clk);
      chk("grant", bus.req_done, 1);
      @(posedge sys_clk); #1;
      bus.addr_done = 1'b1;
      bus.addr_use  = {5'(s), m};
      @(negedge sys_clk);
      chk("grant_once", bus.req_done, 0);
      @(posedge sys_clk); #1;
      bus.addr_done = 1'b0;
      bus.req_addr  = 1'b0;
      bus.addr_use  = '1;
      for (int j = 0; j < 512; j++) if (m[j]) mdl[s][j] = 1'b1;
      push_exp(s);
      wait_done("alloc", 514);
   endtask

   task automatic do_free(input int s, input int st, input int len, input bit track);
      @(posedge sys_clk); #1;
      bus.free_vld   = 1'b1;
      bus.free_sram  = 5'(s);
      bus.free_start = 9'(st);
      bus.free_len   = 8'(len);
      @(negedge sys_clk);
      chk("free_rdy", bus.free_rdy, 1);
      @(posedge sys_clk); #1;
      bus.free_vld   = 1'b0;
      bus.free_start = '1;
      bus.free_len   = '1;
      if (track) begin
         for (int j = st; j < st + len && j < 512; j++) mdl[s][j] = 1'b0;
         push_exp(s);
         wait_done("free", 514);
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got no finish expected finish before 2ms");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_addr   = 1'b0;
      bus.addr_done  = 1'b0;
      bus.addr_use   = '0;
      bus.free_vld   = 1'b0;
      bus.free_sram  = '0;
      bus.free_start = '0;
      bus.free_len   = '0;
      model_reset();

      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      chk("rst_free_rdy", bus.free_rdy, 0);
      chk("rst_req_done", bus.req_done, 0);
      chk("rst_scan_busy", bus.scan_busy, 0);
      chk("rst_cnt", bus.sram_idle_cnt, {32{9'd511}});
      chk("rst_addr", bus.sram_addr, '0);
      @(posedge sys_clk); #1;
      sys_rst = 1'b0;
      @(negedge sys_clk);
      chk("idle_free_rdy", bus.free_rdy, 1);

      do_alloc(0, rng(0, 3));
      chk("sram0_cnt_508", bus.sram_idle_cnt[8:0], 508);
      chk("sram0_addr_4", bus.sram_addr[8:0], 4);

      do_alloc(2, rng(0, 9) | rng(20, 29));
      do_free(2, 5, 5, 1);
      chk("sram2_cnt_a", bus.sram_idle_cnt[2*9 +: 9], 482);
      chk("sram2_addr_a", bus.sram_addr[2*9 +: 9], 30);
      do_free(2, 10, 10, 1);
      chk("sram2_cnt_b", bus.sram_idle_cnt[2*9 +: 9], 482);
      chk("sram2_addr_b", bus.sram_addr[2*9 +: 9], 30);

      do_free(0, 100, 0, 1);

      // Release and request arrive together: release first, grant only after its commit.
      do_alloc(4, rng(0, 99));
      @(posedge sys_clk); #1;
      bus.free_vld   = 1'b1;
      bus.free_sram  = 5'd4;
      bus.free_start = 9'd0;
      bus.free_len   = 8'd50;
      bus.req_addr   = 1'b1;
      @(negedge sys_clk);
      chk("prio_free_rdy", bus.free_rdy, 1);
      @(posedge sys_clk); #1;
      bus.free_vld = 1'b0;
      for (int j = 0; j < 50; j++) mdl[4][j] = 1'b0;
      push_exp(4);
      wait_done("prio", 514);
      chk("prio_no_early_grant", bus.req_done, 0);
      @(posedge sys_clk); #1;
      @(negedge sys_clk);
      chk("prio_grant", bus.req_done, 1);
      @(posedge sys_clk); #1;
      bus.addr_done = 1'b1;
      bus.addr_use  = {5'd4, rng(100, 109)};
      @(negedge sys_clk);
      chk("prio_grant_once", bus.req_done, 0);
      @(posedge sys_clk); #1;
      bus.addr_done = 1'b0;
      bus.req_addr  = 1'b0;
      for (int j = 100; j < 110; j++) mdl[4][j] = 1'b1;
      push_exp(4);
      wait_done("prio_alloc", 514);
      chk("sram4_cnt", bus.sram_idle_cnt[4*9 +: 9], 402);

      do_alloc(7, '1);
      chk("sram7_full_cnt", bus.sram_idle_cnt[7*9 +: 9], 0);
      chk("sram7_full_addr", bus.sram_addr[7*9 +: 9], 0);
      do_free(7, 500, 20, 1);
      chk("sram7_tail_cnt", bus.sram_idle_cnt[7*9 +: 9], 12);
      chk("sram7_tail_addr", bus.sram_addr[7*9 +: 9], 500);
      do_alloc(5, '0);

      // Reset in the middle of a rescan discards the release and clears everything.
      do_alloc(3, rng(0, 199));
      do_free(3, 0, 100, 0);
      repeat (100) @(posedge sys_clk);
      #1;
      sys_rst = 1'b1;
      @(posedge sys_clk);
      @(negedge sys_clk);
      chk("midrst_busy", bus.scan_busy, 0);
      chk("midrst_free_rdy", bus.free_rdy, 0);
      chk("midrst_cnt", bus.sram_idle_cnt, {32{9'd511}});
      chk("midrst_addr", bus.sram_addr, '0);
      model_reset();
      @(posedge sys_clk); #1;
      sys_rst = 1'b0;
      @(negedge sys_clk);
      chk("midrst_idle", bus.free_rdy, 1);
      do_alloc(3, rng(0, 9));
      chk("post_rst_cnt", bus.sram_idle_cnt[3*9 +: 9], 502);

      for (int i = 0; i < 16; i++) begin
         int s;
         s = $urandom_range(0, 5);
         if ($urandom_range(0, 1) == 0) begin
            logic [511:0] m;
            int lo;
            m = '0;
            for (int r = $urandom_range(0, 3); r > 0; r--) begin
               lo = $urandom_range(0, 511);
               m  = m | rng(lo, lo + $urandom_range(0, 119));
            end
            do_alloc(s, m);
         end else begin
            do_free(s, $urandom_range(0, 511), $urandom_range(0, 255), 1);
         end
      end

      repeat (5) @(negedge sys_clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
